// File: rtl/ysyx_24100012_core_ctrl.sv
// Multi-cycle core sequencer: fetch, execute, memory, write-back.
// Moore request outputs, Mealy ir_we, sticky halt/fault status.
module ysyx_24100012_core_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ifu_req_valid,
    input  logic                  ifu_req_ready,
    input  logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_err,
    output logic                  ir_we,
    input  logic                  dec_MemREn,
    input  logic                  dec_MemWEn,
    input  logic                  dec_WEn,
    input  logic                  dec_CSRWEn,
    input  logic [1:0]            dec_csrType,
    input  logic                  is_ebreak,
    output logic                  lsu_req_valid,
    input  logic                  lsu_req_ready,
    input  logic                  lsu_rsp_valid,
    input  logic                  lsu_rsp_err,
    output logic                  rf_we,
    output logic                  csr_we,
    output logic                  pc_we,
    output logic [DATA_WIDTH-1:0] retire_cnt,
    output logic                  halted,
    output logic                  fault,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_IWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_MWAIT = 3'd5,
        S_WB    = 3'd6,
        S_STOP  = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] retire_q, retire_d;
    logic                  halted_q, halted_d;
    logic                  fault_q, fault_d;
    logic                  in_wb;

    // Next-state and status update; responses only count in their wait state
    always_comb begin
        state_d  = state_q;
        retire_d = retire_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ifu_req_ready) state_d = S_IWAIT;
            end
            S_IWAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        fault_d = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (is_ebreak) begin
                    halted_d = 1'b1;
                    state_d  = S_STOP;
                end else if (dec_MemREn | dec_MemWEn) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (lsu_req_ready) state_d = S_MWAIT;
            end
            S_MWAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        fault_d = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire_d = retire_q + 1'b1;
                state_d  = S_FETCH;
            end
            S_STOP: state_d = S_STOP;
        endcase
    end

    // State and status registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            retire_q <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign in_wb         = (state_q == S_WB);
    assign ifu_req_valid = (state_q == S_FETCH);
    assign lsu_req_valid = (state_q == S_MEM);
    assign ir_we         = (state_q == S_IWAIT) & ifu_rsp_valid & ~ifu_rsp_err;
    assign pc_we         = in_wb;
    assign rf_we         = in_wb & dec_WEn;
    assign csr_we        = in_wb & (dec_CSRWEn | (dec_csrType == 2'b01));
    assign retire_cnt    = retire_q;
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign state         = state_q;

endmodule

// File: tb/tb_ysyx_24100012_core_ctrl.sv
// Directed bench for the core sequencer with a transaction-level
// expectation model checked every cycle on the falling edge.
module tb_ysyx_24100012_core_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic        ifu_rsp_valid = 1'b0;
    logic        ifu_rsp_err = 1'b0;
    logic        ir_we;
    logic        dec_MemREn = 1'b0;
    logic        dec_MemWEn = 1'b0;
    logic        dec_WEn = 1'b0;
    logic        dec_CSRWEn = 1'b0;
    logic [1:0]  dec_csrType = 2'b11;
    logic        is_ebreak = 1'b0;
    logic        lsu_req_valid;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        lsu_rsp_err = 1'b0;
    logic        rf_we;
    logic        csr_we;
    logic        pc_we;
    logic [31:0] retire_cnt;
    logic        halted;
    logic        fault;
    logic [2:0]  state;

    ysyx_24100012_core_ctrl #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_err   (ifu_rsp_err),
        .ir_we         (ir_we),
        .dec_MemREn    (dec_MemREn),
        .dec_MemWEn    (dec_MemWEn),
        .dec_WEn       (dec_WEn),
        .dec_CSRWEn    (dec_CSRWEn),
        .dec_csrType   (dec_csrType),
        .is_ebreak     (is_ebreak),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_err   (lsu_rsp_err),
        .rf_we         (rf_we),
        .csr_we        (csr_we),
        .pc_we         (pc_we),
        .retire_cnt    (retire_cnt),
        .halted        (halted),
        .fault         (fault),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // expectation for the current cycle
    logic        chk_en = 1'b0;
    logic [2:0]  e_st;
    logic        e_irv, e_irw, e_lrv, e_rf, e_csr, e_pc;
    logic [31:0] cnt_m = '0;
    logic        halted_m = 1'b0;
    logic        fault_m = 1'b0;
    bit          noise = 1'b0;

    int          rfwe_n = 0;
    int          ifuv_n = 0;
    int          lsuv_n = 0;
    logic [2:0]  st_log[$];

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (rf_we) rfwe_n++;
        if (ifu_req_valid) ifuv_n++;
        if (lsu_req_valid) lsuv_n++;
        st_log.push_back(state);
        if (chk_en) begin
            n_checks++;
            if ({state, ifu_req_valid, ir_we, lsu_req_valid, rf_we, csr_we,
                 pc_we, halted, fault, retire_cnt} !==
                {e_st, e_irv, e_irw, e_lrv, e_rf, e_csr, e_pc,
                 halted_m, fault_m, cnt_m}) begin
                n_err++;
                $display("FAIL cycle t=%0t got st=%0d irv=%b irw=%b lrv=%b rf=%b csr=%b pc=%b h=%b f=%b cnt=%0h expected st=%0d irv=%b irw=%b lrv=%b rf=%b csr=%b pc=%b h=%b f=%b cnt=%0h",
                         $time, state, ifu_req_valid, ir_we, lsu_req_valid,
                         rf_we, csr_we, pc_we, halted, fault, retire_cnt,
                         e_st, e_irv, e_irw, e_lrv, e_rf, e_csr, e_pc,
                         halted_m, fault_m, cnt_m);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic expect_out(input logic [2:0] st, input logic irv,
                              input logic irw, input logic lrv,
                              input logic rf, input logic csr,
                              input logic pc);
        e_st  = st;
        e_irv = irv;
        e_irw = irw;
        e_lrv = lrv;
        e_rf  = rf;
        e_csr = csr;
        e_pc  = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic noise_ifu();
        ifu_rsp_valid = noise;
        ifu_rsp_err   = noise;
    endtask

    task automatic noise_lsu();
        lsu_rsp_valid = noise;
        lsu_rsp_err   = noise;
    endtask

    task automatic clear_inputs();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_err   = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_err   = 1'b0;
        is_ebreak     = 1'b0;
        dec_MemREn    = 1'b0;
        dec_MemWEn    = 1'b0;
        dec_WEn       = 1'b0;
        dec_CSRWEn    = 1'b0;
        dec_csrType   = 2'b11;
    endtask

    // hold reset, then release; one IDLE cycle follows
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cnt_m    = '0;
        halted_m = 1'b0;
        fault_m  = 1'b0;
        chk_en   = 1'b1;
        expect_out(3'd0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        noise_ifu();
        noise_lsu();
        step();
    endtask

    task automatic stop_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            noise_ifu();
            noise_lsu();
            ifu_req_ready = 1'b1;
            lsu_req_ready = 1'b1;
            expect_out(3'd7, 0, 0, 0, 0, 0, 0);
            step();
        end
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
    endtask

    // One instruction from FETCH; returns after WB, STOP entry or reset.
    task automatic run_instr(input int fd, input int rd, input bit ferr,
                             input bit ebrk, input bit mre, input bit mwe,
                             input int md, input int mr, input bit merr,
                             input bit wen, input bit csrwen,
                             input logic [1:0] ct, input bit abort);
        for (int i = 0; i <= fd; i++) begin
            ifu_req_ready = (i == fd);
            noise_ifu();
            noise_lsu();
            expect_out(3'd1, 1, 0, 0, 0, 0, 0);
            step();
        end
        ifu_req_ready = 1'b0;
        for (int i = 0; i <= rd; i++) begin
            noise_lsu();
            ifu_rsp_valid = (i == rd);
            ifu_rsp_err   = (i == rd) && ferr;
            expect_out(3'd2, 0, (i == rd) && !ferr, 0, 0, 0, 0);
            step();
        end
        if (ferr) begin
            fault_m = 1'b1;
            return;
        end
        noise_ifu();
        noise_lsu();
        is_ebreak   = ebrk;
        dec_MemREn  = mre;
        dec_MemWEn  = mwe;
        dec_WEn     = wen;
        dec_CSRWEn  = csrwen;
        dec_csrType = ct;
        expect_out(3'd3, 0, 0, 0, 0, 0, 0);
        step();
        is_ebreak = 1'b0;
        if (ebrk) begin
            halted_m = 1'b1;
            return;
        end
        if (mre || mwe) begin
            for (int i = 0; i <= md; i++) begin
                lsu_req_ready = (i == md);
                noise_lsu();
                expect_out(3'd4, 0, 0, 1, 0, 0, 0);
                step();
            end
            lsu_req_ready = 1'b0;
            for (int i = 0; i <= mr; i++) begin
                if (abort) begin
                    lsu_rsp_valid = 1'b0;
                    check("mwait_before_rst", state, 3'd5);
                    rst = 1'b1;
                    #1;
                    check("rst_async_state", state, 3'd0);
                    check("rst_async_cnt", retire_cnt, 32'd0);
                    cnt_m    = '0;
                    halted_m = 1'b0;
                    fault_m  = 1'b0;
                    expect_out(3'd0, 0, 0, 0, 0, 0, 0);
                    return;
                end
                lsu_rsp_valid = (i == mr);
                lsu_rsp_err   = (i == mr) && merr;
                expect_out(3'd5, 0, 0, 0, 0, 0, 0);
                step();
            end
            if (merr) begin
                fault_m = 1'b1;
                return;
            end
        end
        noise_ifu();
        noise_lsu();
        expect_out(3'd6, 0, 0, 0, wen, csrwen | (ct == 2'b01), 1);
        step();
        cnt_m = cnt_m + 1;
    endtask

    initial begin
        logic [11:0] tr;
        clear_inputs();
        #1;
        do_reset();
        check("reset_cnt", retire_cnt, 32'd0);

        // zero-wait ADDI
        st_log.delete();
        rfwe_n = 0;
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0);
        check("addi_state_after", state, 3'd1);
        check("addi_trace_len", 64'(st_log.size()), 64'd4);
        tr = '0;
        for (int i = 0; i < st_log.size() && i < 4; i++)
            tr = {tr[8:0], st_log[i]};
        check("addi_trace", tr, {3'd1, 3'd2, 3'd3, 3'd6});
        check("addi_rfwe_cycles", 64'(rfwe_n), 64'd1);
        check("addi_cnt", retire_cnt, 32'd1);

        // load, lsu_req_ready delayed 3 cycles
        lsuv_n = 0;
        run_instr(0, 0, 0, 0, 1, 0, 3, 1, 0, 1, 0, 2'b11, 0);
        check("load_lsu_valid_cycles", 64'(lsuv_n), 64'd4);
        check("load_cnt", retire_cnt, 32'd2);

        // ECALL, MRET, CSR write, store with noise on idle channels
        noise = 1'b1;
        run_instr(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
        run_instr(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0);
        run_instr(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0);
        run_instr(1, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0, 2'b11, 0);
        check("mixed_cnt", retire_cnt, 32'd6);

        // counter wrap: preload during FETCH
        force dut.retire_q = 32'hFFFF_FFFF;
        cnt_m = 32'hFFFF_FFFF;
        #2;
        release dut.retire_q;
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0);
        check("wrap_cnt", retire_cnt, 32'd0);

        // fetch access fault
        run_instr(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0);
        stop_cycles(5);
        check("ifetch_fault", fault, 1'b1);
        do_reset();
        check("fault_cleared_state", state, 3'd1);
        check("fault_cleared", fault, 1'b0);

        // data access fault
        run_instr(0, 0, 0, 0, 1, 0, 1, 2, 1, 1, 0, 2'b11, 0);
        stop_cycles(4);
        check("data_fault", fault, 1'b1);
        do_reset();

        // reset in the middle of MWAIT with a response pending afterwards
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0);
        run_instr(0, 0, 0, 0, 1, 0, 0, 2, 0, 1, 0, 2'b11, 1);
        step();
        rst = 1'b0;
        noise_ifu();
        noise_lsu();
        expect_out(3'd0, 0, 0, 0, 0, 0, 0);
        step();
        run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0);
        check("after_abort_cnt", retire_cnt, 32'd1);

        // EBREAK halts for good
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2'b11, 0);
        ifuv_n = 0;
        stop_cycles(100);
        check("ebreak_no_fetch", 64'(ifuv_n), 64'd0);
        check("ebreak_halted", halted, 1'b1);
        check("ebreak_state", state, 3'd7);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24100012_core_ctrl.md
YSYX_24100012_CORE_CTRL -- requirements
Module: ysyx_24100012_core_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the retire counter.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port ifu_req_valid, output, 1 bit: instruction fetch request.
REQ-005 SHALL have port ifu_req_ready, input, 1 bit: the fetch request is accepted.
REQ-006 SHALL have port ifu_rsp_valid, input, 1 bit: the instruction word is available.
REQ-007 SHALL have port ifu_rsp_err, input, 1 bit: fetch access fault; qualified by ifu_rsp_valid.
REQ-008 SHALL have port ir_we, output, 1 bit: latches the instruction register for the decoder.
REQ-009 SHALL have port dec_MemREn, dec_MemWEn, dec_WEn, dec_CSRWEn, inputs, 1 bit each: decoder control signals.
REQ-010 SHALL have port dec_csrType, input, 2 bits: 00 normal CSR, 01 ECALL, 10 MRET, 11 none.
REQ-011 SHALL have port is_ebreak, input, 1 bit: the decoded instruction is EBREAK.
REQ-012 SHALL have port lsu_req_valid, output, 1 bit: data memory request.
REQ-013 SHALL have port lsu_req_ready, input, 1 bit: the data memory request is accepted.
REQ-014 SHALL have port lsu_rsp_valid, input, 1 bit: the load data or store acknowledge is available.
REQ-015 SHALL have port lsu_rsp_err, input, 1 bit: data access fault; qualified by lsu_rsp_valid.
REQ-016 SHALL have port rf_we, csr_we, pc_we, outputs, 1 bit each: commit strobes.
REQ-017 SHALL have port retire_cnt, output, DATA_WIDTH bits: count of retired instructions.
REQ-018 SHALL have port halted, output, 1 bit: EBREAK reached. Port fault, output, 1 bit: access error.
REQ-019 SHALL have port state, output, 3 bits: current FSM state encoding, for debug.

Function
REQ-020 SHALL implement the states IDLE=0, FETCH=1, IWAIT=2, EXEC=3, MEM=4, MWAIT=5, WB=6, STOP=7.
REQ-021 SHALL move IDLE->FETCH unconditionally on the first clock edge after rst deasserts.
REQ-022 SHALL assert ifu_req_valid in FETCH only, held until ifu_req_ready; FETCH->IWAIT on the edge where valid&ready.
REQ-023 In IWAIT on ifu_rsp_valid: SHALL pulse ir_we for one cycle and go to EXEC if ifu_rsp_err=0, else set fault and go to STOP with ir_we=0.
REQ-024 SHALL ignore ifu_rsp_valid outside IWAIT, and lsu_rsp_valid outside MWAIT.
REQ-025 EXEC is one cycle: SHALL go to STOP with halted=1 if is_ebreak; else to MEM if dec_MemREn|dec_MemWEn; else to WB.
REQ-026 SHALL assert lsu_req_valid in MEM only, held until lsu_req_ready; MEM->MWAIT on valid&ready.
REQ-027 In MWAIT on lsu_rsp_valid: SHALL go to WB if lsu_rsp_err=0, else set fault and go to STOP.
REQ-028 In WB for one cycle: SHALL assert pc_we=1, rf_we=dec_WEn, and csr_we=dec_CSRWEn|(dec_csrType==01); then increment retire_cnt and go to FETCH.
REQ-029 The rf_we, csr_we and pc_we strobes SHALL be 0 in every state other than WB.
REQ-030 retire_cnt SHALL wrap modulo 2^DATA_WIDTH, with no saturation.
REQ-031 STOP SHALL be absorbing until reset; halted and fault SHALL be sticky.
REQ-032 STOP SHALL drive all request outputs and strobes to 0.
REQ-033 Minimum latency SHALL be 4 cycles per non-memory instruction (FETCH, IWAIT, EXEC, WB) and 6 cycles per load/store.
REQ-034 Request outputs SHALL be Moore outputs, decoded from state only.
REQ-035 ir_we SHALL be Mealy, formed as IWAIT & ifu_rsp_valid & ~ifu_rsp_err.

Reset
REQ-036 rst=1 SHALL asynchronously force state=IDLE, retire_cnt=0, halted=0, fault=0, and all other outputs 0, including in the middle of a handshake.
REQ-037 After reset, an outstanding response from before reset SHALL be ignored, per REQ-024.

Verification
REQ-038 Zero-wait ADDI: ready=1 and rsp_valid one cycle after request -> states 1,2,3,6,1; rf_we=1 for exactly one cycle; retire_cnt=1.
REQ-039 Load with lsu_req_ready delayed 3 cycles: lsu_req_valid held for 4 cycles; WB reached; retire_cnt increments by 1.
REQ-040 ECALL (dec_csrType=01, dec_WEn=0) -> csr_we=1 and rf_we=0 in WB.
REQ-041 is_ebreak=1 in EXEC -> state=7 and halted=1, with no further ifu_req_valid for 100 cycles.
REQ-042 ifu_rsp_err=1 in IWAIT -> ir_we=0 and fault=1 in STOP; rst pulse -> IDLE, fault=0.
REQ-043 retire_cnt preloaded via force to 0xFFFFFFFF, then one retire -> 0x00000000; rst asserted in MWAIT -> state=0 immediately.
